rr_arbiter_4: RTL
=================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one resource between four clients.
- Winner index is held as a 2-bit registered code; one-hot grant lines are the 2-to-4 decode of that code.
- Grant is held while the owner keeps requesting, with optional forced rotation after MAX_HOLD cycles.
- Sits in front of any shared datapath whose select lines are driven by a 2x4 decode.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold the grant while others wait. 0 means unlimited. Legal range 0..15.
- HOLD_W, 4: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- gnt  output  4  registered one-hot grant; all zero when idle.
- gnt_id  output  2  registered index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  registered; high when a grant is active.

Behaviour:
- Reset (async, rst_n low) takes effect immediately, mid-operation included:
  - state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, hold_cnt=0.
  - Last-grant pointer ptr=2'b11, so requester 0 has first priority after reset.
- States: IDLE, GRANT. All outputs are registered; no combinational path from req to gnt.
- Priority search: starts at ptr+1 and proceeds ptr+2, ptr+3, ptr, modulo 4 with wrap-around. The first set req bit wins.
- IDLE:
  - req==0: stay in IDLE, outputs stay zero.
  - Any req set: on the next edge, gnt_id=winner, gnt=decode(winner), gnt_valid=1, ptr=winner, hold_cnt=1, go to GRANT.
  - Latency is exactly 1 cycle from req sampled high to gnt high.
- GRANT, owner release (req[gnt_id]==0 at the edge):
  - If any other req is set, grant the next winner on the same edge (searching from the old owner+1): no bubble, hold_cnt=1, ptr=new winner.
  - If no req is set, go to IDLE: gnt=0, gnt_valid=0; gnt_id keeps its last value.
- GRANT, owner still requesting:
  - MAX_HOLD!=0, hold_cnt==MAX_HOLD and some other req set: forced rotation on this edge to the next winner, excluding the current owner; hold_cnt=1.
  - Otherwise keep the grant; hold_cnt increments, saturating at MAX_HOLD (or at its all-ones value when MAX_HOLD=0).
- Requests arriving while another client is granted are seen only at the next arbitration point: release or forced rotation.
- A single requester with no competition keeps the grant indefinitely, even at MAX_HOLD.
- Invariants, checked every cycle:
  - gnt is zero or one-hot.
  - gnt_valid==|gnt.
  - When gnt_valid=1, gnt==(4'b0001<<gnt_id).
- No grant is ever issued to a requester whose req was low at the deciding edge.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, then release. Required: gnt=0 during reset; one cycle after release, gnt=4'b0001, gnt_id=0. Assert rst_n mid-GRANT: gnt drops to 0 immediately, without waiting for a clock edge.
- Rotation: hold req=4'b1111, owner drops req for one cycle each time it is granted. Required: grant order 0,1,2,3,0, each handover with no idle cycle.
- Wrap-around: owner=3 releases while req=4'b0011. Required: next gnt=4'b0001, not 4'b0010.
- Forced rotation: MAX_HOLD=8, req=4'b0101 held constant. Required: gnt=4'b0001 for exactly 8 cycles, then 4'b0100 for 8 cycles, alternating.
- Lone requester: req=4'b0010 held for 20 cycles. Required: gnt=4'b0010 for all cycles and hold_cnt saturates. Then drop req: one cycle later gnt=0 and gnt_valid=0.
- Randomized bench: 10k cycles with random req. Required: all invariants hold, and no requester waits more than 3*MAX_HOLD+3 cycles with req held high.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with registered grant and hold limit
// The owner keeps the grant while requesting; after MAX_HOLD cycles it is forced off if others wait.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);
  localparam bit                FORCE_EN = (MAX_HOLD != 0);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        id_q, id_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [3:0] others;
  logic [2:0] pick_any, pick_oth;
  logic       do_grant;
  logic [1:0] win;

  // Returns {found, index}; the search begins one past base and wraps, so base itself is tried last.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!res[2] && mask[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    gnt_d    = gnt_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    win      = 2'b00;
    others   = req & ~(4'b0001 << id_q);
    // ptr_q always equals the current or most recent owner, so one search origin serves both states.
    pick_any = rr_pick(req, ptr_q);
    pick_oth = rr_pick(others, ptr_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          do_grant = 1'b1;
          win      = pick_any[1:0];
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          if (|req) begin
            do_grant = 1'b1;
            win      = pick_any[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (FORCE_EN && (hold_q == HOLD_SAT) && (|others)) begin
          do_grant = 1'b1;
          win      = pick_oth[1:0];
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d = GRANT;
      id_d    = win;
      ptr_d   = win;
      gnt_d   = 4'b0001 << win;
      valid_d = 1'b1;
      hold_d  = HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'b11;
      id_q    <= 2'b00;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;

endmodule
